ring_buffer_i2s_tx: RTL and testbench
=====================================

Name: ring_buffer_i2s_tx

Overview:
- Consumer end of the sample ring buffer. Pops one sample per audio frame through the buffer's read port and serialises it as left-justified stereo (same sample on both channels) to an external DAC.
- Generates bit clock, word-select and serial data from the system clock.
- Outputs silence when the buffer underruns, and counts underruns.

Parameters:
- WIDTH, 16, bits per sample. Must match the ring buffer width; WIDTH >= 2.
- BCLK_DIV, 2, clk cycles per bclk half-period; >= 1.
- CNT_W, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run/stop; sampled each clk.
- fifo_read_enable  out  WIDTH? no, 1  registered pop request to the ring buffer's read_enable.
- fifo_data  in  WIDTH  ring buffer data_out; valid from the edge after a pop.
- fifo_empty  in  1  ring buffer empty flag.
- bclk  out  1  serial bit clock.
- lrclk  out  1  word select: 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse per underrun.
- underrun_count  out  CNT_W  saturating count of underruns.

Behaviour:
- Reset: bclk=0, lrclk=0, sdata=0, fifo_read_enable=0, underrun=0, underrun_count=0. Divider, slot counter, shift register and next_sample are cleared; fetch FSM goes to IDLE.
- Reset mid-frame aborts the frame immediately. No pop is issued while rst is high.
- Divider: counts 0..BCLK_DIV-1. On terminal count, bclk toggles.
  - bclk period = 2*BCLK_DIV clk.
  - Slot boundary = the edge where bclk goes 1->0.
  - Slot counter runs 0..2*WIDTH-1, then wraps.
- Format: left-justified.
  - lrclk = 0 for slots 0..WIDTH-1 and 1 for slots WIDTH..2*WIDTH-1.
  - Slot k carries bit WIDTH-1-(k mod WIDTH).
  - sdata and lrclk change only at slot boundaries, i.e. on the bclk falling edge; the DAC samples on the bclk rising edge.
  - Right half replays the same word; the shift register is reloaded from the held sample at slot WIDTH.
- Frame-start event occurs on either:
  - the slot-counter wrap to 0, or
  - the first clk with enable=1 after enable=0 or reset.
- At a frame-start event:
  - shift <= next_sample; sdata <= next_sample[WIDTH-1]; lrclk <= 0.
  - Divider restarts at 0 with bclk=0.
- Fetch FSM (IDLE -> REQ -> CAPT -> IDLE):
  - At the frame-start edge, if fifo_empty=0 the FSM goes to REQ and fifo_read_enable <= 1.
  - REQ: exactly one cycle with fifo_read_enable=1; the ring buffer pops at the end of this cycle. At that edge fifo_read_enable <= 0 and the FSM goes to CAPT.
  - CAPT: next_sample <= fifo_data at the end of the cycle, then IDLE.
  - Pop latency: the sample popped in frame n is played in frame n+1.
  - At most one pop per frame; fifo_read_enable is never high for two consecutive cycles.
- Underrun:
  - Condition: fifo_empty=1 at the frame-start edge.
  - Response: no pop; next_sample <= 0; underrun pulses for one cycle; underrun_count increments.
  - underrun_count saturates at 2^CNT_W-1.
- Enable:
  - enable=0 holds bclk, lrclk, sdata and fifo_read_enable at 0 and the FSM in IDLE; no pops.
  - next_sample is retained.
  - A deassert during REQ completes that pop and its CAPT so the popped word is not lost.
  - A deassert mid-frame truncates the frame; re-enable starts a fresh frame at slot 0.
- Widths: slot counter is clog2(2*WIDTH) bits; divider is max(1, clog2(BCLK_DIV)) bits; all arithmetic is unsigned and wraps only where stated.

Test Plan:
- Reset, then enable=1 with fifo_empty=0 and fifo_data=16'hA5C3 (WIDTH=16, BCLK_DIV=2):
  - fifo_read_enable is high for exactly one cycle, the cycle after enable rises.
  - Frame 0 plays all zeros.
  - Frame 1 sdata = A5C3 MSB-first with lrclk=0, then A5C3 again with lrclk=1.
  - Frame length is 128 clk cycles.
- Checker on a frame: bclk period = 4 clk; lrclk and sdata transitions occur only on bclk falling edges; lrclk toggles every 16 bclk periods.
- Drive fifo_empty=1 at a frame start:
  - No pop; underrun pulses for one cycle; underrun_count 0->1.
  - The next frame outputs 0x0000.
  - Refill: normal playback resumes one frame later.
- Force underrun_count to 16'hFFFE, then cause 3 underruns: the count reads FFFF and stays there; underrun still pulses each time.
- Deassert enable during the REQ cycle:
  - The pop completes and the word is captured.
  - bclk, lrclk and sdata are 0 while disabled.
  - On re-enable the captured word plays in the first frame.
- Assert rst mid-frame while fifo_read_enable=1: all outputs go to reset values immediately; no further pop occurs until enable is high and rst is low.

Source files
------------

// File: rtl/ring_buffer_i2s_tx.sv
// ring_buffer_i2s_tx: pops one ring-buffer sample per frame and serialises it as
// left-justified stereo (same word on both channels), with underrun silencing and counting.
module ring_buffer_i2s_tx #(
    parameter int WIDTH    = 16,
    parameter int BCLK_DIV = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             fifo_read_enable,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_count
);
    localparam int SW = $clog2(2 * WIDTH);
    localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

    state_t           state;
    logic [DW-1:0]    div;
    logic [SW-1:0]    slot;
    logic [WIDTH-1:0] shift, next_sample, rot;
    logic             en_q, tc, fall, wrap, start;

    // Rotating rather than shifting leaves the word intact after WIDTH slots,
    // so the right channel replays it without a separate reload path.
    always_comb begin
        tc    = div == DW'(BCLK_DIV - 1);
        fall  = tc && bclk;
        wrap  = fall && slot == SW'(2 * WIDTH - 1);
        start = enable && (!en_q || wrap);
        rot   = {shift[WIDTH-2:0], shift[WIDTH-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            div              <= '0;
            slot             <= '0;
            shift            <= '0;
            next_sample      <= '0;
            en_q             <= 1'b0;
            bclk             <= 1'b0;
            lrclk            <= 1'b0;
            sdata            <= 1'b0;
            fifo_read_enable <= 1'b0;
            underrun         <= 1'b0;
            underrun_count   <= '0;
        end else begin
            en_q             <= enable;
            underrun         <= 1'b0;
            fifo_read_enable <= 1'b0;
            if (start) begin
                div   <= '0;
                bclk  <= 1'b0;
                slot  <= '0;
                shift <= next_sample;
                sdata <= next_sample[WIDTH-1];
                lrclk <= 1'b0;
            end else if (!enable) begin
                div   <= '0;
                bclk  <= 1'b0;
                slot  <= '0;
                sdata <= 1'b0;
                lrclk <= 1'b0;
            end else begin
                div <= tc ? '0 : div + 1'b1;
                if (tc) bclk <= !bclk;
                if (fall) begin
                    slot  <= slot + 1'b1;
                    shift <= rot;
                    sdata <= rot[WIDTH-1];
                    lrclk <= slot >= SW'(WIDTH - 1);
                end
            end
            // REQ and CAPT run to completion regardless of enable so a popped word is never lost.
            if (state == REQ) begin
                state <= CAPT;
            end else if (state == CAPT) begin
                next_sample <= fifo_data;
                state       <= IDLE;
            end else if (start) begin
                if (fifo_empty) begin
                    next_sample <= '0;
                    underrun    <= 1'b1;
                    if (~&underrun_count) underrun_count <= underrun_count + 1'b1;
                end else begin
                    state            <= REQ;
                    fifo_read_enable <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ring_buffer_i2s_tx.sv
// tb_ring_buffer_i2s_tx: randomized frame-level checks against a sample-queue model
// (one-frame pop latency, underrun silence, saturating count), plus a tiny-config saturation run.
module tb_ring_buffer_i2s_tx;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, fifo_empty = 1'b1;
    logic [15:0] fifo_data = '0;
    logic        fifo_read_enable, bclk, lrclk, sdata, underrun;
    logic [15:0] underrun_count;
    logic        enable_s = 1'b0, fifo_empty_s = 1'b1;
    logic [1:0]  fifo_data_s = 2'b01;
    logic        fifo_read_enable_s, bclk_s, lrclk_s, sdata_s, underrun_s;
    logic [1:0]  underrun_count_s;
    int          checks = 0, failures = 0;
    logic [15:0] model_next = '0;
    int          model_cnt = 0;

    ring_buffer_i2s_tx #(.WIDTH(16), .BCLK_DIV(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_read_enable(fifo_read_enable),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .bclk(bclk), .lrclk(lrclk),
        .sdata(sdata), .underrun(underrun), .underrun_count(underrun_count)
    );

    ring_buffer_i2s_tx #(.WIDTH(2), .BCLK_DIV(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .enable(enable_s), .fifo_read_enable(fifo_read_enable_s),
        .fifo_data(fifo_data_s), .fifo_empty(fifo_empty_s), .bclk(bclk_s), .lrclk(lrclk_s),
        .sdata(sdata_s), .underrun(underrun_s), .underrun_count(underrun_count_s)
    );

    always #5 clk = ~clk;

    // One full 128-cycle frame; the frame-start edge is the next posedge after the call.
    task automatic capture_frame(input logic [15:0] data, input logic empty, input string name);
        logic [15:0] play, got_l, got_r;
        int nb, nl, ns, nf, nu;
        play = model_next;
        if (empty) begin
            model_next = '0;
            if (model_cnt < 65535) model_cnt++;
        end else model_next = data;
        fifo_data = data;
        fifo_empty = empty;
        nb = 0; nl = 0; ns = 0; nf = 0; nu = 0; got_l = '0; got_r = '0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (bclk !== ((i % 4) >= 2)) nb++;
            if (lrclk !== (i >= 64)) nl++;
            if (sdata !== play[15 - (i / 4) % 16]) ns++;
            if (fifo_read_enable !== (i == 0 && !empty)) nf++;
            if (underrun !== (i == 0 && empty)) nu++;
            if (i % 4 == 2) begin
                if (i < 64) got_l[15 - i / 4] = sdata;
                else got_r[15 - (i / 4 - 16)] = sdata;
            end
        end
        checks += 8;
        if (nb !== 0) begin failures++; $display("FAIL %s bclk_pattern: bad_cycles=%0d expected 0", name, nb); end
        if (nl !== 0) begin failures++; $display("FAIL %s lrclk_pattern: bad_cycles=%0d expected 0", name, nl); end
        if (ns !== 0) begin failures++; $display("FAIL %s sdata_timing: bad_cycles=%0d expected 0", name, ns); end
        if (got_l !== play) begin failures++; $display("FAIL %s left_word: got %h expected %h", name, got_l, play); end
        if (got_r !== play) begin failures++; $display("FAIL %s right_word: got %h expected %h", name, got_r, play); end
        if (nf !== 0) begin failures++; $display("FAIL %s pop_pattern: bad_cycles=%0d expected 0", name, nf); end
        if (nu !== 0) begin failures++; $display("FAIL %s underrun_pulse: bad_cycles=%0d expected 0", name, nu); end
        if (underrun_count !== 16'(model_cnt)) begin
            failures++; $display("FAIL %s underrun_count: got %h expected %h", name, underrun_count, 16'(model_cnt));
        end
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        checks++;
        if ({bclk, lrclk, sdata, fifo_read_enable, underrun, underrun_count} !== 21'b0) begin
            failures++; $display("FAIL reset_values: got %b expected 0", {bclk, lrclk, sdata, fifo_read_enable, underrun, underrun_count});
        end
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if ({bclk, lrclk, sdata, fifo_read_enable} !== 4'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL idle_disabled: bad_cycles=%0d expected 0", bad); end
    endtask

    task automatic test_basic();
        enable = 1'b1;
        capture_frame(16'hA5C3, 1'b0, "basic_frame0");
        capture_frame(16'hA5C3, 1'b0, "basic_frame1");
    endtask

    task automatic test_underrun();
        capture_frame(16'h1234, 1'b1, "underrun_frame");
        capture_frame(16'hBEEF, 1'b0, "silence_frame");
        capture_frame(16'($urandom), 1'b0, "refill_frame");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) capture_frame(16'($urandom), $urandom_range(0, 3) == 0, "random_frame");
    endtask

    task automatic test_enable_req();
        int bad;
        fifo_data = 16'hD00D;
        fifo_empty = 1'b0;
        model_next = 16'hD00D;
        @(negedge clk);
        checks++;
        if (fifo_read_enable !== 1'b1) begin failures++; $display("FAIL req_pop: got %b expected 1", fifo_read_enable); end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({bclk, lrclk, sdata, fifo_read_enable} !== 4'b0) begin
            failures++; $display("FAIL disable_outputs: got %b expected 0000", {bclk, lrclk, sdata, fifo_read_enable});
        end
        @(negedge clk);
        fifo_data = 16'h5555;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({bclk, lrclk, sdata, fifo_read_enable} !== 4'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL disabled_hold: bad_cycles=%0d expected 0", bad); end
        enable = 1'b1;
        capture_frame(16'($urandom), 1'b0, "reenable_frame");
    endtask

    task automatic test_reset_mid();
        int bad;
        fifo_data = 16'h7777;
        fifo_empty = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_read_enable !== 1'b1) begin failures++; $display("FAIL pre_reset_pop: got %b expected 1", fifo_read_enable); end
        rst = 1'b1;
        model_next = '0;
        model_cnt = 0;
        #1;
        checks++;
        if ({bclk, lrclk, sdata, fifo_read_enable, underrun, underrun_count} !== 21'b0) begin
            failures++; $display("FAIL async_reset: got %b expected 0", {bclk, lrclk, sdata, fifo_read_enable, underrun, underrun_count});
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (fifo_read_enable !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL pop_in_reset: bad_cycles=%0d expected 0", bad); end
        rst = 1'b0;
        capture_frame(16'($urandom), 1'b0, "post_reset_frame");
    endtask

    task automatic test_saturate();
        int pulses, bad, pops;
        logic prev;
        pulses = 0; bad = 0; pops = 0; prev = 1'b0;
        enable_s = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (underrun_s) begin
                pulses++;
                if (prev) bad++;
                if (underrun_count_s !== 2'(pulses > 3 ? 3 : pulses)) bad++;
            end
            if (fifo_read_enable_s) pops++;
            prev = underrun_s;
        end
        checks += 4;
        if (pulses !== 5) begin failures++; $display("FAIL sat_pulses: got %0d expected 5", pulses); end
        if (bad !== 0) begin failures++; $display("FAIL sat_sequence: bad=%0d expected 0", bad); end
        if (underrun_count_s !== 2'd3) begin failures++; $display("FAIL sat_count: got %0d expected 3", underrun_count_s); end
        if (pops !== 0) begin failures++; $display("FAIL sat_no_pop: got %0d expected 0", pops); end
        enable_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_random();
        test_enable_req();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
